// File: rtl/chan_deser_buff.sv
// chan_deser_buff: double-buffered serial-to-parallel capture buffer.
// Collects NDATA samples from each of NCHAN one-bit lanes into ping-pong
// banks and hands complete frames out over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ena        sample strobe (din captured when ena=1)
//   din        one serial bit per lane
//   wr_cnt     index of the next sample within the current frame
//   dout       read-bank contents, lane c at dout[c*NDATA +: NDATA]
//   dout_valid read bank holds a complete, unconsumed frame
//   dout_ready consumer accepts the frame (with dout_valid)
//   overflow   sticky: a sample was dropped with both banks full

// Per-lane storage: two NDATA-bit bank words, one write port, one read mux.
module chan_deser_lane #(
    parameter int NDATA     = 128,
    parameter int NDATA_LOG = $clog2(NDATA)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 wsel,
    input  logic                 rsel,
    input  logic [NDATA_LOG-1:0] pos,
    input  logic                 bit_in,
    output logic [NDATA-1:0]     word
);
    logic [1:0][NDATA-1:0] bank;

    always_ff @(posedge clk) begin
        if (rst)
            bank <= '0;
        else if (we)
            bank[wsel][pos] <= bit_in;
    end

    assign word = bank[rsel];
endmodule

module chan_deser_buff #(
    parameter int NCHAN     = 4,
    parameter int NDATA     = 128,
    parameter bit MSB_FIRST = 1'b0,
    localparam int NDATA_LOG = $clog2(NDATA)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [NCHAN-1:0]       din,
    output logic [NDATA_LOG-1:0]   wr_cnt,
    output logic [NCHAN*NDATA-1:0] dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   overflow
);
    typedef enum logic [1:0] {FILL0, FILL1, STALL} state_t;

    localparam logic [NDATA_LOG-1:0] LAST = NDATA_LOG'(NDATA - 1);

    state_t               state;
    logic                 wbank;
    logic                 rbank;
    logic                 we;
    logic                 fc;
    logic                 cs;
    logic [NDATA_LOG-1:0] pos;

    // Samples arriving while both banks are full are dropped.
    assign we  = ena && (state != STALL);
    assign fc  = we && (wr_cnt == LAST);
    assign cs  = dout_valid && dout_ready;
    assign pos = MSB_FIRST ? (LAST - wr_cnt) : wr_cnt;

    genvar c;
    generate
        for (c = 0; c < NCHAN; c++) begin : g_lane
            chan_deser_lane #(.NDATA(NDATA), .NDATA_LOG(NDATA_LOG)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .we     (we),
                .wsel   (wbank),
                .rsel   (rbank),
                .pos    (pos),
                .bit_in (din[c]),
                .word   (dout[c*NDATA +: NDATA])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL0;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            wr_cnt     <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            // Explicit wrap so non-power-of-two NDATA never reaches NDATA.
            if (we)
                wr_cnt <= fc ? '0 : wr_cnt + 1'b1;
            if (state == STALL && ena)
                overflow <= 1'b1;
            case (state)
                FILL0: begin
                    if (fc) begin
                        state      <= FILL1;
                        rbank      <= wbank;
                        wbank      <= ~wbank;
                        dout_valid <= 1'b1;
                    end
                end
                FILL1: begin
                    if (cs && fc) begin
                        // Hand over the fresh frame and reuse the freed bank.
                        rbank <= wbank;
                        wbank <= ~wbank;
                    end else if (cs) begin
                        state      <= FILL0;
                        dout_valid <= 1'b0;
                    end else if (fc) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (cs) begin
                        // Newest frame becomes readable; consumed bank is refilled.
                        state <= FILL1;
                        rbank <= wbank;
                        wbank <= rbank;
                    end
                end
                default: begin
                    state      <= FILL0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chan_deser_buff.sv
// tb_chan_deser_buff: drives two instances (LSB-first and MSB-first) with
// directed and random stimulus. A frame-level reference model pushes
// expected frames into queues; a monitor compares on each presented frame.
module tb_chan_deser_buff;
    localparam int NCHAN = 4;
    localparam int NDATA = 8;
    localparam int NL    = $clog2(NDATA);
    localparam int W     = NCHAN * NDATA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             rdy = 1'b0;
    logic [NCHAN-1:0] din = '0;

    logic [NL-1:0] wr_cnt0, wr_cnt1;
    logic [W-1:0]  dout0, dout1;
    logic          vld0, vld1, ovf0, ovf1;

    chan_deser_buff #(.NCHAN(NCHAN), .NDATA(NDATA), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .wr_cnt(wr_cnt0),
        .dout(dout0), .dout_valid(vld0), .dout_ready(rdy), .overflow(ovf0));

    chan_deser_buff #(.NCHAN(NCHAN), .NDATA(NDATA), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .wr_cnt(wr_cnt1),
        .dout(dout1), .dout_valid(vld1), .dout_ready(rdy), .overflow(ovf1));

    int npass = 0;
    int ntot  = 0;

    // Reference model: frames as flat bit vectors, pending frame count.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] part0 = '0;
    logic [W-1:0] part1 = '0;
    int           idx   = 0;
    int           pend  = 0;
    bit           ovf   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic lanes(input string nm, input logic [W-1:0] d,
                         input logic [7:0] l0, input logic [7:0] lr);
        chk({nm, "_lane0"}, 64'(d[NDATA-1:0]), 64'(l0));
        for (int c = 1; c < NCHAN; c++)
            chk({nm, "_laneN"}, 64'(d[c*NDATA +: NDATA]), 64'(lr));
    endtask

    task automatic cyc(input bit e, input logic [NCHAN-1:0] d, input bit r);
        ena = e;
        din = d;
        rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_frame(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(1'b1, NCHAN'($urandom), r);
    endtask

    // Model update on each edge from the inputs held stable across it.
    initial begin
        bit cs;
        forever begin
            @(posedge clk);
            if (rst) begin
                q0.delete();
                q1.delete();
                pend  = 0;
                idx   = 0;
                ovf   = 1'b0;
                part0 = '0;
                part1 = '0;
            end else begin
                cs = (pend > 0) && rdy;
                if (ena) begin
                    if (pend == 2) begin
                        ovf = 1'b1;
                    end else begin
                        for (int c = 0; c < NCHAN; c++) begin
                            part0[c*NDATA + idx]             = din[c];
                            part1[c*NDATA + NDATA - 1 - idx] = din[c];
                        end
                        idx++;
                        if (idx == NDATA) begin
                            idx = 0;
                            q0.push_back(part0);
                            q1.push_back(part1);
                            pend++;
                        end
                    end
                end
                if (cs) pend--;
            end
        end
    end

    // Monitor: compare status every cycle, frame content whenever presented.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("wr_cnt0", 64'(wr_cnt0), 64'(idx));
            chk("wr_cnt1", 64'(wr_cnt1), 64'(idx));
            chk("valid0", 64'(vld0), 64'(pend > 0));
            chk("valid1", 64'(vld1), 64'(pend > 0));
            chk("ovf0", 64'(ovf0), 64'(ovf));
            chk("ovf1", 64'(ovf1), 64'(ovf));
            if (vld0) begin
                ntot++;
                if (q0.size() == 0) begin
                    $display("FAIL frame0: valid with no expected frame, dout %0h at %0t", dout0, $time);
                end else if (dout0 !== q0[0]) begin
                    $display("FAIL frame0: got %0h expected %0h at %0t", dout0, q0[0], $time);
                end else npass++;
                if (rdy && q0.size() > 0) void'(q0.pop_front());
            end
            if (vld1) begin
                ntot++;
                if (q1.size() == 0) begin
                    $display("FAIL frame1: valid with no expected frame, dout %0h at %0t", dout1, $time);
                end else if (dout1 !== q1[0]) begin
                    $display("FAIL frame1: got %0h expected %0h at %0t", dout1, q1[0], $time);
                end else npass++;
                if (rdy && q1.size() > 0) void'(q1.pop_front());
            end
        end
    end

    initial begin
        // Reset, some random activity, then reset again for two cycles.
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'($urandom), NCHAN'($urandom), 1'($urandom));
        rst = 1'b1;
        cyc(1'($urandom), NCHAN'($urandom), 1'b0);
        cyc(1'($urandom), NCHAN'($urandom), 1'b0);
        rst = 1'b0;
        chk("rst_wr_cnt", 64'(wr_cnt0), 64'd0);
        chk("rst_dout0", 64'(dout0), 64'd0);
        chk("rst_dout1", 64'(dout1), 64'd0);
        chk("rst_valid", 64'(vld0), 64'd0);
        chk("rst_ovf", 64'(ovf0), 64'd0);

        // Single alternating frame.
        for (int i = 0; i < NDATA; i++) cyc(1'b1, (i % 2 == 0) ? 4'h1 : 4'hE, 1'b0);
        chk("alt_valid", 64'(vld0), 64'd1);
        chk("alt_wr_cnt", 64'(wr_cnt0), 64'd0);
        lanes("alt_lsb", dout0, 8'h55, 8'hAA);
        lanes("alt_msb", dout1, 8'hAA, 8'h55);
        cyc(1'b0, '0, 1'b1);
        chk("alt_consumed", 64'(vld0), 64'd0);

        // Gapped strobes, all-ones frame; left pending as frame A.
        for (int i = 0; i < NDATA; i++) begin
            cyc(1'b1, 4'hF, 1'b0);
            cyc(1'b0, 4'h0, 1'b0);
            cyc(1'b0, 4'h0, 1'b0);
        end
        lanes("gap", dout0, 8'hFF, 8'hFF);

        // Back-pressure: frame B fills the second bank, then overflow.
        for (int i = 0; i < NDATA; i++) cyc(1'b1, (i < 4) ? 4'hF : 4'h0, 1'b0);
        lanes("stall_a", dout0, 8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) cyc(1'b1, NCHAN'($urandom), 1'b0);
        chk("stall_ovf", 64'(ovf0), 64'd1);
        chk("stall_wr_cnt", 64'(wr_cnt0), 64'd0);
        cyc(1'b1, NCHAN'($urandom), 1'b1);
        chk("stall_cs_valid", 64'(vld0), 64'd1);
        lanes("stall_b", dout0, 8'h0F, 8'h0F);
        cyc(1'b0, '0, 1'b1);

        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        rst = 1'b0;

        // Consume and complete on the same edge.
        rnd_frame(NDATA, 1'b0);
        rnd_frame(NDATA - 1, 1'b0);
        cyc(1'b1, NCHAN'($urandom), 1'b1);
        chk("csfc_valid", 64'(vld0), 64'd1);
        chk("csfc_ovf", 64'(ovf0), 64'd0);
        rnd_frame(NDATA, 1'b0);
        chk("csfc_ovf2", 64'(ovf0), 64'd0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);

        // Mid-frame reset with one frame pending.
        rnd_frame(NDATA, 1'b0);
        rnd_frame(5, 1'b0);
        chk("mid_wr_cnt", 64'(wr_cnt0), 64'd5);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        rst = 1'b0;
        chk("mid_valid", 64'(vld0), 64'd0);
        chk("mid_dout0", 64'(dout0), 64'd0);
        chk("mid_dout1", 64'(dout1), 64'd0);
        rnd_frame(NDATA, 1'b0);
        cyc(1'b0, '0, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            cyc(($urandom_range(0, 3) != 0), NCHAN'($urandom), ($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;
        cyc(1'b0, '0, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
